mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
Shares the processor's single-port unified memory between instruction fetch and data load/store. Sits between the fetch unit / load-store unit and the memory inside top. Issues one memory command at a time, tracks the fixed read latency and routes the returned word to the owning requester. Data has priority by default, so an in-flight instruction's load/store finishes before the next fetch.

Parameters:
ADDR_WIDTH, 32, byte address width for both requesters and memory.
MEM_LATENCY, 1, cycles from mem_en to mem_rdata valid; legal range 1..4.

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset (0 = in reset)
if_req  in  1  fetch request; held with if_addr until if_gnt
if_addr  in  ADDR_WIDTH  fetch address
if_gnt  out  1  fetch command accepted this cycle
if_rvalid  out  1  one-cycle pulse; if_rdata valid
if_rdata  out  32  fetched instruction
d_req  in  1  data request; held with payload until d_gnt
d_we  in  1  1 = store, 0 = load
d_addr  in  ADDR_WIDTH  data address
d_wdata  in  32  store data
d_wmask  in  4  byte enables for stores
d_gnt  out  1  data command accepted this cycle
d_rvalid  out  1  one-cycle completion pulse for loads and stores; d_rdata valid for loads
d_rdata  out  32  load data
mem_en  out  1  memory command strobe
mem_we  out  1  memory write enable
mem_addr  out  ADDR_WIDTH  memory address
mem_wdata  out  32  memory write data
mem_wmask  out  4  memory byte enables
mem_rdata  in  32  memory read data, valid MEM_LATENCY cycles after mem_en

Behaviour:
- States: IDLE, BUSY. Registers: state, owner (FETCH/DATA), cnt (0..MEM_LATENCY-1).
- Reset (reset=0): state=IDLE, owner=FETCH, cnt=0. if_gnt, d_gnt, if_rvalid, d_rvalid, mem_en, mem_we = 0. mem_wmask=0. Data buses 0.
- Grant is combinational from state and requests. A grant is possible in IDLE, or in BUSY on the completion cycle (cnt==MEM_LATENCY-1).
- Selection: if only one request is pending, that request wins. If both are pending, DATA wins.
- Grant cycle T: the winner's gnt=1 and mem_en=1. mem_addr, mem_we, mem_wdata and mem_wmask are driven from the winner; for fetches, mem_we=0 and mem_wmask=0. Next state is BUSY, owner=winner, cnt=0.
- BUSY: cnt increments each cycle. Completion occurs in cycle T+MEM_LATENCY. In that cycle, the owner's rvalid=1 and rdata=mem_rdata (combinational pass-through). If a new grant is made in the same cycle, the arbiter stays BUSY and reloads the owner; otherwise it returns to IDLE.
- Throughput: one transaction per MEM_LATENCY cycles. Single outstanding transaction.
- Stores also complete at T+MEM_LATENCY with d_rvalid=1. d_rdata is don't-care for stores.
- Both gnts are never 1 in the same cycle. rvalid pulses only for the owner.
- When not granted, mem_en=0 and memory outputs hold their last value.
- A req dropped before gnt is a protocol violation; the arbiter must not hang, and the request is simply not served.
- Reset asserted mid-transaction: the transaction is abandoned, no rvalid is produced, and the arbiter is IDLE after release.
- rvalid is independent of whether the same requester re-requests in the completion cycle; back-to-back transactions to the same requester are allowed.

Optional Feature:
ARB_ROUND_ROBIN_EN
- Defined: contested selection is round-robin. A last_winner register (reset value FETCH) makes the requester that did not win last time win the tie, so with both continuously requesting, grants alternate D, F, D, F...
- Undefined: fixed DATA-over-FETCH priority; no last_winner register.
- Uncontested behaviour is identical in both builds.

Decomposition:
- mem_arb_pkg: owner_t enum {OWN_FETCH, OWN_DATA}; state_t enum {ARB_IDLE, ARB_BUSY}; constant MAX_MEM_LATENCY=4.
- One sub-module, mem_arb_pick: combinational winner selection from if_req, d_req, grant-allowed and last_winner, with the ARB_ROUND_ROBIN_EN variant inside.
- Top-level mem_port_arbiter holds the FSM, counter and muxes.

Test Plan:
1. Reset, then if_req=1, if_addr=0x0000_0010, MEM_LATENCY=1, model returns 0x0000_0513 -> if_gnt at T, mem_en=1, mem_addr=0x10, if_rvalid=1 with if_rdata=0x0000_0513 at T+1; d_rvalid stays 0.
2. Both if_req and d_req (load, d_addr=0x100) held, default build -> d_gnt first; if_gnt on d_rvalid cycle; mem_addr sequence 0x100 then fetch address; both gnts never high together.
3. Store d_addr=0x200, d_wdata=0xDEAD_BEEF, d_wmask=4'b0011 -> mem_we=1, mem_wmask=0011, mem_wdata=0xDEADBEEF at grant; d_rvalid pulse at T+MEM_LATENCY; a subsequent fetch has mem_we=0.
4. MEM_LATENCY=3, continuous fetches -> if_gnt every 3 cycles; if_rvalid 3 cycles after each grant, coinciding with the next grant; no idle gap.
5. Assert reset=0 one cycle after a load grant with MEM_LATENCY=3 -> no d_rvalid ever appears for that load; all outputs 0 during reset; normal grant on first request after release.
6. ARB_ROUND_ROBIN_EN defined, both requests held for 6 transactions -> grant order D, F, D, F, D, F (last_winner reset FETCH).

Source files
------------

// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared types and constants for the unified-memory port arbiter.
//   owner_t         : which requester owns the in-flight memory transaction
//   state_t         : arbiter FSM states
//   MAX_MEM_LATENCY : largest supported memory read latency (cycles)
//   CNT_W           : width of the latency counter
package mem_arb_pkg;

    typedef enum logic {
        OWN_FETCH = 1'b0,
        OWN_DATA  = 1'b1
    } owner_t;

    typedef enum logic {
        ARB_IDLE = 1'b0,
        ARB_BUSY = 1'b1
    } state_t;

    localparam int MAX_MEM_LATENCY = 4;
    localparam int CNT_W           = $clog2(MAX_MEM_LATENCY);

endpackage

// File: rtl/mem_arb_pick.sv
// mem_arb_pick: combinational winner selection between fetch and data.
// Configuration macro: ARB_ROUND_ROBIN_EN
//   undefined : data always wins a contested cycle
//   defined   : the requester that did not win last time wins a contested cycle
// Ports:
//   if_req, d_req : pending requests
//   allow         : a grant may be issued this cycle
//   last_winner   : owner of the most recent grant (only used when round-robin)
//   pick_if       : fetch wins this cycle
//   pick_d        : data wins this cycle
// pick_if and pick_d are mutually exclusive by construction.
module mem_arb_pick
    import mem_arb_pkg::*;
(
    input  logic   if_req,
    input  logic   d_req,
    input  logic   allow,
    input  owner_t last_winner,
    output logic   pick_if,
    output logic   pick_d
);

    logic prefer_d;

`ifdef ARB_ROUND_ROBIN_EN
    assign prefer_d = (last_winner == OWN_FETCH);
`else
    logic unused_last_winner;
    assign unused_last_winner = last_winner;
    assign prefer_d           = 1'b1;
`endif

    // An uncontested request always wins; prefer_d only breaks ties.
    assign pick_d  = allow && d_req && (!if_req || prefer_d);
    assign pick_if = allow && if_req && !pick_d;

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares a single-port memory between instruction fetch and
// data load/store. One command in flight at a time; the returned word is routed
// to the requester that issued it after a fixed MEM_LATENCY.
// Configuration macro: ARB_ROUND_ROBIN_EN (round-robin tie break, see mem_arb_pick).
// Parameters:
//   ADDR_WIDTH  : byte address width
//   MEM_LATENCY : cycles from mem_en to mem_rdata valid, 1..MAX_MEM_LATENCY
// Ports:
//   clk, reset (async, active-low)
//   if_req/if_addr -> if_gnt, if_rvalid/if_rdata       : fetch requester
//   d_req/d_we/d_addr/d_wdata/d_wmask -> d_gnt,
//     d_rvalid/d_rdata                                 : load/store requester
//   mem_en/mem_we/mem_addr/mem_wdata/mem_wmask,
//     mem_rdata                                        : memory side
//   dbg_state, dbg_owner                               : FSM observation
// Handshake: a requester holds req and its payload stable until the cycle its
// gnt is 1; gnt and mem_en are combinational in that cycle. Exactly
// MEM_LATENCY cycles later rvalid pulses for one cycle with the result.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_WIDTH  = 32,
    parameter int MEM_LATENCY = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  if_req,
    input  logic [ADDR_WIDTH-1:0] if_addr,
    output logic                  if_gnt,
    output logic                  if_rvalid,
    output logic [31:0]           if_rdata,
    input  logic                  d_req,
    input  logic                  d_we,
    input  logic [ADDR_WIDTH-1:0] d_addr,
    input  logic [31:0]           d_wdata,
    input  logic [3:0]            d_wmask,
    output logic                  d_gnt,
    output logic                  d_rvalid,
    output logic [31:0]           d_rdata,
    output logic                  mem_en,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [31:0]           mem_wdata,
    output logic [3:0]            mem_wmask,
    input  logic [31:0]           mem_rdata,
    output state_t                dbg_state,
    output owner_t                dbg_owner
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_LATENCY - 1);

    state_t            state, state_nxt;
    owner_t            owner, owner_nxt;
    logic [CNT_W-1:0]  cnt, cnt_nxt;
    owner_t            last_winner;

    // Memory command bus is held between grants.
    logic [ADDR_WIDTH-1:0] hold_addr;
    logic                  hold_we;
    logic [31:0]           hold_wdata;
    logic [3:0]            hold_wmask;

    logic done;
    logic allow;
    logic pick_if;
    logic pick_d;
    logic grant;

    assign done  = (state == ARB_BUSY) && (cnt == CNT_LAST);
    // reset gates allow so no grant escapes while the arbiter is held in reset.
    assign allow = reset && ((state == ARB_IDLE) || done);
    assign grant = pick_if || pick_d;

    mem_arb_pick u_pick (
        .if_req      (if_req),
        .d_req       (d_req),
        .allow       (allow),
        .last_winner (last_winner),
        .pick_if     (pick_if),
        .pick_d      (pick_d)
    );

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= ARB_IDLE;
            owner <= OWN_FETCH;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            owner <= owner_nxt;
            cnt   <= cnt_nxt;
        end
    end

`ifdef ARB_ROUND_ROBIN_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            last_winner <= OWN_FETCH;
        end else if (grant) begin
            last_winner <= pick_d ? OWN_DATA : OWN_FETCH;
        end
    end
`else
    assign last_winner = OWN_FETCH;
`endif

    // Held memory command fields, captured from whatever was driven at grant.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hold_addr  <= '0;
            hold_we    <= 1'b0;
            hold_wdata <= '0;
            hold_wmask <= '0;
        end else if (grant) begin
            hold_addr  <= mem_addr;
            hold_we    <= mem_we;
            hold_wdata <= mem_wdata;
            hold_wmask <= mem_wmask;
        end
    end

    // Next state and outputs
    always_comb begin
        state_nxt = state;
        owner_nxt = owner;
        cnt_nxt   = cnt;

        // A grant on the completion cycle reloads the FSM, giving back-to-back
        // transactions with no idle gap.
        if (grant) begin
            state_nxt = ARB_BUSY;
            owner_nxt = pick_d ? OWN_DATA : OWN_FETCH;
            cnt_nxt   = '0;
        end else if (state == ARB_BUSY) begin
            if (done) begin
                state_nxt = ARB_IDLE;
                cnt_nxt   = '0;
            end else begin
                cnt_nxt = cnt + 1'b1;
            end
        end

        if_gnt    = pick_if;
        d_gnt     = pick_d;
        mem_en    = grant;
        mem_addr  = hold_addr;
        mem_we    = hold_we;
        mem_wdata = hold_wdata;
        mem_wmask = hold_wmask;
        if (pick_d) begin
            mem_addr  = d_addr;
            mem_we    = d_we;
            mem_wdata = d_wdata;
            mem_wmask = d_wmask;
        end else if (pick_if) begin
            // Fetches are reads; write data is left as it was.
            mem_addr  = if_addr;
            mem_we    = 1'b0;
            mem_wmask = 4'b0000;
        end

        if_rvalid = done && (owner == OWN_FETCH);
        d_rvalid  = done && (owner == OWN_DATA);
        if_rdata  = if_rvalid ? mem_rdata : 32'h0;
        d_rdata   = d_rvalid  ? mem_rdata : 32'h0;

        dbg_state = state;
        dbg_owner = owner;
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: two instances (MEM_LATENCY 1 and 3) share one
// stimulus stream; a transaction-level reference model per instance predicts
// grants, memory bus values and completions from absolute cycle times.
module tb_mem_port_arbiter;
    import mem_arb_pkg::*;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset = 1'b0;
    logic        if_req = 1'b0, d_req = 1'b0, d_we = 1'b0;
    logic [31:0] if_addr = '0, d_addr = '0, d_wdata = '0, mem_rdata = '0;
    logic [3:0]  d_wmask = '0;

    logic        if_gnt_0, if_rvalid_0, d_gnt_0, d_rvalid_0, mem_en_0, mem_we_0;
    logic [31:0] if_rdata_0, d_rdata_0, mem_addr_0, mem_wdata_0;
    logic [3:0]  mem_wmask_0;
    state_t      dbg_state_0;
    owner_t      dbg_owner_0;
    logic        if_gnt_1, if_rvalid_1, d_gnt_1, d_rvalid_1, mem_en_1, mem_we_1;
    logic [31:0] if_rdata_1, d_rdata_1, mem_addr_1, mem_wdata_1;
    logic [3:0]  mem_wmask_1;
    state_t      dbg_state_1;
    owner_t      dbg_owner_1;

    mem_port_arbiter #(.ADDR_WIDTH(32), .MEM_LATENCY(1)) u_dut0 (
        .clk(clk), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt_0),
        .if_rvalid(if_rvalid_0), .if_rdata(if_rdata_0),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_wmask(d_wmask), .d_gnt(d_gnt_0), .d_rvalid(d_rvalid_0), .d_rdata(d_rdata_0),
        .mem_en(mem_en_0), .mem_we(mem_we_0), .mem_addr(mem_addr_0),
        .mem_wdata(mem_wdata_0), .mem_wmask(mem_wmask_0), .mem_rdata(mem_rdata),
        .dbg_state(dbg_state_0), .dbg_owner(dbg_owner_0)
    );

    mem_port_arbiter #(.ADDR_WIDTH(32), .MEM_LATENCY(3)) u_dut1 (
        .clk(clk), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt_1),
        .if_rvalid(if_rvalid_1), .if_rdata(if_rdata_1),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_wmask(d_wmask), .d_gnt(d_gnt_1), .d_rvalid(d_rvalid_1), .d_rdata(d_rdata_1),
        .mem_en(mem_en_1), .mem_we(mem_we_1), .mem_addr(mem_addr_1),
        .mem_wdata(mem_wdata_1), .mem_wmask(mem_wmask_1), .mem_rdata(mem_rdata),
        .dbg_state(dbg_state_1), .dbg_owner(dbg_owner_1)
    );

    // ---------------- scoreboard ----------------
    int n_checks = 0;
    int n_err    = 0;
    longint cyc  = 0;
    bit  capture = 1'b0;
    logic [0:0] exp_q[$];   // expected grant owner sequence for the latency-3 instance (1 = data)

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // reference model state, one entry per instance
    int          lat[2] = '{1, 3};
    bit          active[2], own_d[2], was_load[2], lw_d[2];
    longint      done_at[2];
    logic [31:0] h_addr[2];
    bit          h_we[2];
    logic [3:0]  h_mask[2];
    bit          gi[2], gd[2];
    // observed values of the most recent checked cycle
    logic        o_ig[2], o_dg[2], o_ir[2], o_dr[2], o_en[2], o_we[2];
    logic [31:0] o_ird[2], o_addr[2], o_wd[2];
    logic [3:0]  o_mask[2];

    task automatic check_model(input int k);
        bit done, allow, prefer_d, pd, pf, e_we;
        logic [31:0] e_addr;
        logic [3:0]  e_mask;
        string p;
        p = $sformatf("L%0d_", lat[k]);
        o_ig[k]  = k ? if_gnt_1    : if_gnt_0;
        o_dg[k]  = k ? d_gnt_1     : d_gnt_0;
        o_ir[k]  = k ? if_rvalid_1 : if_rvalid_0;
        o_dr[k]  = k ? d_rvalid_1  : d_rvalid_0;
        o_en[k]  = k ? mem_en_1    : mem_en_0;
        o_we[k]  = k ? mem_we_1    : mem_we_0;
        o_ird[k] = k ? if_rdata_1  : if_rdata_0;
        o_addr[k]= k ? mem_addr_1  : mem_addr_0;
        o_wd[k]  = k ? mem_wdata_1 : mem_wdata_0;
        o_mask[k]= k ? mem_wmask_1 : mem_wmask_0;

        if (!reset) begin
            active[k] = 0; lw_d[k] = 0; h_addr[k] = '0; h_we[k] = 0; h_mask[k] = '0;
        end
        done  = active[k] && (cyc == done_at[k]);
        allow = reset && (!active[k] || done);
`ifdef ARB_ROUND_ROBIN_EN
        prefer_d = !lw_d[k];
`else
        prefer_d = 1'b1;
`endif
        pd = allow && d_req && (!if_req || prefer_d);
        pf = allow && if_req && !pd;
        e_addr = pd ? d_addr  : (pf ? if_addr : h_addr[k]);
        e_we   = pd ? d_we    : (pf ? 1'b0    : h_we[k]);
        e_mask = pd ? d_wmask : (pf ? 4'h0    : h_mask[k]);

        chk({p, "if_gnt"}, o_ig[k], pf);
        chk({p, "d_gnt"}, o_dg[k], pd);
        chk({p, "both_gnt"}, o_ig[k] & o_dg[k], 0);
        chk({p, "mem_en"}, o_en[k], pd | pf);
        chk({p, "mem_addr"}, o_addr[k], e_addr);
        chk({p, "mem_we"}, o_we[k], e_we);
        chk({p, "mem_wmask"}, o_mask[k], e_mask);
        if (pd && d_we) chk({p, "mem_wdata"}, o_wd[k], d_wdata);
        chk({p, "if_rvalid"}, o_ir[k], done && !own_d[k]);
        chk({p, "d_rvalid"}, o_dr[k], done && own_d[k]);
        if (done && !own_d[k]) chk({p, "if_rdata"}, o_ird[k], mem_rdata);
        if (done && own_d[k] && was_load[k])
            chk({p, "d_rdata"}, k ? d_rdata_1 : d_rdata_0, mem_rdata);
        if (!reset) begin
            chk({p, "rst_if_rdata"}, o_ird[k], 0);
            chk({p, "rst_d_rdata"}, k ? d_rdata_1 : d_rdata_0, 0);
            chk({p, "rst_mem_wdata"}, o_wd[k], 0);
        end
        if (k == 1 && capture && (o_ig[k] || o_dg[k])) begin
            if (exp_q.size() == 0) chk("grant_order_extra", o_dg[k], 1'bx);
            else chk("grant_order", o_dg[k], exp_q.pop_front());
        end

        if (pd || pf) begin
            active[k] = 1; done_at[k] = cyc + lat[k]; own_d[k] = pd;
            was_load[k] = !d_we; lw_d[k] = pd;
            h_addr[k] = e_addr; h_we[k] = e_we; h_mask[k] = e_mask;
        end else if (done) begin
            active[k] = 0;
        end
        gi[k] = pf;
        gd[k] = pd;
    endtask

    // ---------------- driver tasks ----------------
    task automatic step();
        @(negedge clk);
        check_model(0);
        check_model(1);
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic idle(input int n);
        if_req = 0; d_req = 0;
        repeat (n) step();
    endtask

    task automatic do_reset(input int n);
        reset = 0;
        repeat (n) step();
        reset = 1;
    endtask

    // ---------------- directed + random sequence ----------------
    initial begin
        int g;
        do_reset(3);

        // 1: single fetch, latency 1
        mem_rdata = 32'h0000_0513;
        if_req = 1; if_addr = 32'h10;
        step();
        chk("t1_if_gnt", o_ig[0], 1);
        chk("t1_mem_en", o_en[0], 1);
        chk("t1_mem_addr", o_addr[0], 32'h10);
        if_req = 0;
        step();
        chk("t1_if_rvalid", o_ir[0], 1);
        chk("t1_if_rdata", o_ird[0], 32'h0000_0513);
        chk("t1_d_rvalid", o_dr[0], 0);
        idle(4);

        // 2: contested load + fetch, data first
        exp_q = '{1'b1, 1'b0};
        capture = 1;
        if_req = 1; if_addr = 32'h40;
        d_req = 1; d_we = 0; d_addr = 32'h100;
        step();
        chk("t2_first_d_gnt", o_dg[1], 1);
        chk("t2_first_addr", o_addr[1], 32'h100);
        if (gd[1]) d_req = 0;
        for (int c = 0; c < 20 && if_req; c++) begin
            mem_rdata = $urandom;
            step();
            if (gi[1]) if_req = 0;
        end
        chk("t2_fetch_served", if_req, 0);
        idle(5);
        capture = 0;
        chk("t2_order_left", exp_q.size(), 0);

        // 3: store then fetch
        d_req = 1; d_we = 1; d_addr = 32'h200; d_wdata = 32'hDEAD_BEEF; d_wmask = 4'b0011;
        step();
        chk("t3_mem_we", o_we[1], 1);
        chk("t3_mem_wmask", o_mask[1], 4'b0011);
        chk("t3_mem_wdata", o_wd[1], 32'hDEAD_BEEF);
        d_req = 0;
        repeat (2) step();
        step();
        chk("t3_d_rvalid", o_dr[1], 1);
        if_req = 1; if_addr = 32'h80;
        for (int c = 0; c < 10 && !gi[1]; c++) step();
        chk("t3_fetch_we", o_we[1], 0);
        idle(4);

        // 4: continuous fetches on latency 3: a grant every third cycle
        g = 0;
        if_req = 1; if_addr = 32'h1000;
        for (int c = 0; c < 12; c++) begin
            mem_rdata = $urandom;
            step();
            if (o_ig[1]) g++;
            if (gi[1]) if_addr = if_addr + 4;
        end
        chk("t4_grant_count", g, 4);
        idle(4);

        // 5: reset one cycle after a load grant
        d_req = 1; d_we = 0; d_addr = 32'h300;
        for (int c = 0; c < 10 && !gd[1]; c++) step();
        d_req = 0;
        step();
        reset = 0;
        for (int c = 0; c < 4; c++) begin
            step();
            chk("t5_rst_mem_en", o_en[1], 0);
            chk("t5_rst_d_rvalid", o_dr[1], 0);
        end
        reset = 1;
        repeat (4) step();
        if_req = 1; if_addr = 32'h400;
        step();
        chk("t5_post_rst_gnt", o_ig[1], 1);
        idle(4);

        // 6: both held for six grants
`ifdef ARB_ROUND_ROBIN_EN
        exp_q = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
`else
        exp_q = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
`endif
        capture = 1;
        if_req = 1; d_req = 1; d_we = 0;
        for (int c = 0; c < 40 && exp_q.size() > 0; c++) begin
            mem_rdata = $urandom;
            step();
            if (gi[1]) if_addr = $urandom & 32'hFFFC;
            if (gd[1]) begin d_addr = $urandom; d_we = $urandom_range(0, 1); end
        end
        capture = 0;
        chk("t6_order_left", exp_q.size(), 0);
        idle(4);

        // random traffic, protocol followed against the latency-3 instance
        for (int c = 0; c < 600; c++) begin
            mem_rdata = $urandom;
            if (if_req && gi[1]) if_req = $urandom_range(0, 1);
            else if (!if_req) if_req = ($urandom_range(0, 9) < 4);
            if (gi[1] || !if_req) if_addr = $urandom;
            if (d_req && gd[1]) d_req = $urandom_range(0, 1);
            else if (!d_req) d_req = ($urandom_range(0, 9) < 4);
            if (gd[1] || !d_req) begin
                d_we = $urandom_range(0, 1); d_addr = $urandom;
                d_wdata = $urandom; d_wmask = 4'($urandom_range(0, 15));
            end
            if ($urandom_range(0, 199) == 0) reset = 0;
            else reset = 1;
            step();
        end
        reset = 1;
        idle(6);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
